// File: rtl/flow_queue_pkg.sv
// Shared types and helpers for flow_queue and related buffers.
package flow_queue_pkg;

  // General-purpose register-sized payload.
  typedef logic [31:0] gpreg;

  // Ring pointer advance that wraps at an arbitrary depth, not a power of two.
  function automatic int unsigned ring_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/flow_queue_if.sv
// Decoupled valid/ready/data channel; fire = valid & ready.
interface flow_queue_if
  import flow_queue_pkg::*;
#(
  parameter type T = gpreg
) ();
  logic valid;
  logic ready;
  T     data;

  // Sender drives valid/data, receiver drives ready.
  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/flow_queue.sv
// Ring-buffer queue with full-depth usage, any depth, optional empty bypass,
// synchronous flush and registered occupancy.
module flow_queue
  import flow_queue_pkg::*;
#(
  parameter type         Data        = gpreg,
  parameter int unsigned Depth       = 2,
  parameter bit          Fallthrough = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst,
  flow_queue_if.slave                enq,
  flow_queue_if.master               deq,
  input  logic                       flush_i,
  output logic [$clog2(Depth+1)-1:0] count_o
);

  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam int unsigned IdxW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [IdxW-1:0] head_q, head_d;
  logic [IdxW-1:0] tail_q, tail_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  Data             store_q [Depth];

  logic full, empty;
  logic enq_fire, deq_fire;
  logic bypass, wr_en;

  assign full  = (cnt_q == CntW'(Depth));
  assign empty = (cnt_q == '0);

  // Ready never looks at deq.ready, so no combinational ready path through the queue.
  assign enq.ready = !full && !flush_i;
  assign deq.valid = Fallthrough ? ((!empty || enq.valid) && !flush_i) : (!empty && !flush_i);
  assign deq.data  = (Fallthrough && empty) ? enq.data : store_q[head_q];

  assign enq_fire = enq.valid && enq.ready;
  assign deq_fire = deq.valid && deq.ready;
  // Empty queue handing the producer's item straight to the consumer: no storage touched.
  assign bypass   = Fallthrough && empty && enq_fire && deq_fire;

  assign count_o = cnt_q;

  // Next-state for pointers and occupancy; flush wins over any handshake.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    wr_en  = 1'b0;
    if (flush_i) begin
      head_d = '0;
      tail_d = '0;
      cnt_d  = '0;
    end else if (!bypass) begin
      if (enq_fire) begin
        wr_en  = 1'b1;
        tail_d = IdxW'(ring_inc(32'(tail_q), Depth));
      end
      if (deq_fire) begin
        head_d = IdxW'(ring_inc(32'(head_q), Depth));
      end
      if (enq_fire && !deq_fire) begin
        cnt_d = cnt_q + 1'b1;
      end else if (deq_fire && !enq_fire) begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  // Pointer and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  // Payload storage; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      store_q[tail_q] <= enq.data;
    end
  end

  a_no_enq_when_full: assert property (@(posedge clk) disable iff (rst) !(enq_fire && full));
  a_no_deq_when_empty: assert property (@(posedge clk) disable iff (rst)
    !(deq_fire && empty && !(Fallthrough && enq_fire)));
  a_cnt_in_range: assert property (@(posedge clk) disable iff (rst) cnt_q <= CntW'(Depth));

endmodule
